// File: rtl/bcd_counter_2digit.sv
// -----------------------------------------------------------------------------
// bcd_counter_2digit
//
// Two-digit BCD up/down counter (00..99) with a prescaler. The prescaler
// counts enabled clock cycles; one count step happens every PRESCALE enabled
// cycles. Both digits are registered and feed a 7-segment decoder downstream.
//
// Parameters
//   PRESCALE : enabled clock cycles per count step (1..16777215)
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous active-high reset (highest priority)
//   en       : count enable, gates the prescaler
//   up       : 1 = count up, 0 = count down (sampled in the step cycle)
//   clr      : synchronous clear to 00 (beats load and step)
//   load     : synchronous parallel load (beats step)
//   ld_tens  : tens digit to load, values above 9 load as 9
//   ld_ones  : ones digit to load, values above 9 load as 9
//   Q_tens   : registered tens digit
//   Q_ones   : registered ones digit
//   carry    : registered one-cycle pulse after a 99->00 up wrap
//   borrow   : registered one-cycle pulse after a 00->99 down wrap
//   tc       : combinational terminal count (99 counting up, 00 counting down)
// -----------------------------------------------------------------------------
module bcd_counter_2digit #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] ld_tens,
    input  logic [3:0] ld_ones,
    output logic [3:0] Q_tens,
    output logic [3:0] Q_ones,
    output logic       carry,
    output logic       borrow,
    output logic       tc
);

    localparam logic [23:0] PRESC_MAX = 24'(PRESCALE - 1);

    logic [23:0]     presc_reg;
    logic [3:0]      tens_reg;
    logic [3:0]      ones_reg;
    logic            carry_reg;
    logic            borrow_reg;
    logic            step;

    // Load digits clamped into BCD range; index 1 = tens, 0 = ones.
    logic [1:0][3:0] ld_digits;
    logic [1:0][3:0] ld_clamped;

    assign ld_digits = {ld_tens, ld_ones};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            assign ld_clamped[gi] = (ld_digits[gi] > 4'd9) ? 4'd9 : ld_digits[gi];
        end
    endgenerate

    assign step = en && (presc_reg == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg  <= '0;
            tens_reg   <= '0;
            ones_reg   <= '0;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else if (clr) begin
            presc_reg  <= '0;
            tens_reg   <= '0;
            ones_reg   <= '0;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else if (load) begin
            presc_reg  <= '0;
            tens_reg   <= ld_clamped[1];
            ones_reg   <= ld_clamped[0];
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else begin
            // Wrap pulses last exactly one cycle unless re-armed below.
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;

            if (en) begin
                presc_reg <= step ? 24'd0 : presc_reg + 24'd1;
            end

            if (step) begin
                if (up) begin
                    // ">= 9" keeps the digits self-correcting back into range.
                    if (ones_reg >= 4'd9) begin
                        ones_reg <= 4'd0;
                        if (tens_reg >= 4'd9) begin
                            tens_reg  <= 4'd0;
                            carry_reg <= 1'b1;
                        end else begin
                            tens_reg <= tens_reg + 4'd1;
                        end
                    end else begin
                        ones_reg <= ones_reg + 4'd1;
                    end
                end else begin
                    if (ones_reg == 4'd0 || ones_reg > 4'd9) begin
                        ones_reg <= 4'd9;
                        if (tens_reg == 4'd0 || tens_reg > 4'd9) begin
                            tens_reg   <= 4'd9;
                            borrow_reg <= 1'b1;
                        end else begin
                            tens_reg <= tens_reg - 4'd1;
                        end
                    end else begin
                        ones_reg <= ones_reg - 4'd1;
                    end
                end
            end
        end
    end

    assign Q_tens = tens_reg;
    assign Q_ones = ones_reg;
    assign carry  = carry_reg;
    assign borrow = borrow_reg;

    assign tc = (up  && tens_reg == 4'd9 && ones_reg == 4'd9) ||
                (!up && tens_reg == 4'd0 && ones_reg == 4'd0);

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_2digit
//
// Directed bench for bcd_counter_2digit. Two instances share all inputs:
// u_dut4 (PRESCALE=4) for prescaler timing, u_dut1 (PRESCALE=1) for per-cycle
// stepping, wrap and load behaviour. Inputs change 1 time unit after the
// rising edge; outputs are sampled in that same window.
// -----------------------------------------------------------------------------
module tb_bcd_counter_2digit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_tens = 4'd0;
    logic [3:0] ld_ones = 4'd0;

    logic [3:0] d4_tens, d4_ones, d1_tens, d1_ones;
    logic       d4_carry, d4_borrow, d4_tc;
    logic       d1_carry, d1_borrow, d1_tc;
    logic [7:0] q4, q1;

    int n_vec = 0;
    int n_err = 0;

    assign q4 = {d4_tens, d4_ones};
    assign q1 = {d1_tens, d1_ones};

    always #5 clk = ~clk;

    bcd_counter_2digit #(.PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .ld_tens(ld_tens), .ld_ones(ld_ones),
        .Q_tens(d4_tens), .Q_ones(d4_ones),
        .carry(d4_carry), .borrow(d4_borrow), .tc(d4_tc)
    );

    bcd_counter_2digit #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .ld_tens(ld_tens), .ld_ones(ld_ones),
        .Q_tens(d1_tens), .Q_ones(d1_ones),
        .carry(d1_carry), .borrow(d1_borrow), .tc(d1_tc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b up=%b clr=%b load=%b | q4=%h c=%b b=%b | q1=%h c=%b b=%b tc=%b",
                 $time, rst, en, up, clr, load, q4, d4_carry, d4_borrow,
                 q1, d1_carry, d1_borrow, d1_tc);
    endtask

    task automatic idle();
        rst = 0; en = 0; clr = 0; load = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        idle(); ld_tens = t; ld_ones = o; load = 1; tick(); load = 0;
    endtask

    task automatic test_reset();
        idle(); up = 1; rst = 1; load = 1; ld_tens = 4'd5; ld_ones = 4'd5;
        tick(); idle();
        n_vec++; if (q4 !== 8'h00 || q1 !== 8'h00) begin n_err++; $display("FAIL reset_q got %h/%h exp 00/00", q4, q1); end
        n_vec++; if ({d4_carry, d4_borrow, d1_carry, d1_borrow} !== 4'b0000) begin n_err++; $display("FAIL reset_cb got %b exp 0000", {d4_carry, d4_borrow, d1_carry, d1_borrow}); end
        n_vec++; if (d1_tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_up got %b exp 0", d1_tc); end
        up = 0; #1;
        n_vec++; if (d1_tc !== 1'b1 || d4_tc !== 1'b1) begin n_err++; $display("FAIL reset_tc_down got %b%b exp 11", d1_tc, d4_tc); end
        up = 1;
    endtask

    task automatic test_count_up();
        logic [7:0] exp;
        int v;
        do_reset(); en = 1; up = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            v = k / 4;
            exp = {4'(v / 10), 4'(v % 10)};
            n_vec++; if (q4 !== exp) begin n_err++; $display("FAIL count_up_k%0d got %h exp %h", k, q4, exp); end
        end
        idle();
    endtask

    task automatic test_wrap_up();
        do_load(4'd9, 4'd8);
        n_vec++; if (q1 !== 8'h98) begin n_err++; $display("FAIL wrap_up_load got %h exp 98", q1); end
        en = 1; up = 1;
        tick();
        n_vec++; if (q1 !== 8'h99 || d1_tc !== 1'b1 || d1_carry !== 1'b0) begin n_err++; $display("FAIL wrap_up_99 got %h tc=%b c=%b exp 99 tc=1 c=0", q1, d1_tc, d1_carry); end
        tick();
        n_vec++; if (q1 !== 8'h00 || d1_carry !== 1'b1 || d1_borrow !== 1'b0) begin n_err++; $display("FAIL wrap_up_00 got %h c=%b b=%b exp 00 c=1 b=0", q1, d1_carry, d1_borrow); end
        tick();
        n_vec++; if (q1 !== 8'h01 || d1_carry !== 1'b0) begin n_err++; $display("FAIL wrap_up_01 got %h c=%b exp 01 c=0", q1, d1_carry); end
        idle();
    endtask

    task automatic test_wrap_down();
        do_load(4'd0, 4'd0);
        up = 0; #1;
        n_vec++; if (q1 !== 8'h00 || d1_tc !== 1'b1) begin n_err++; $display("FAIL wrap_dn_tc got %h tc=%b exp 00 tc=1", q1, d1_tc); end
        en = 1;
        tick();
        n_vec++; if (q1 !== 8'h99 || d1_borrow !== 1'b1 || d1_carry !== 1'b0) begin n_err++; $display("FAIL wrap_dn_99 got %h b=%b c=%b exp 99 b=1 c=0", q1, d1_borrow, d1_carry); end
        tick();
        n_vec++; if (q1 !== 8'h98 || d1_borrow !== 1'b0 || d1_tc !== 1'b0) begin n_err++; $display("FAIL wrap_dn_98 got %h b=%b tc=%b exp 98 b=0 tc=0", q1, d1_borrow, d1_tc); end
        idle(); up = 1;
    endtask

    task automatic test_load_clamp();
        do_load(4'hF, 4'hA);
        n_vec++; if (q1 !== 8'h99 || q4 !== 8'h99) begin n_err++; $display("FAIL clamp_FA got %h/%h exp 99", q1, q4); end
        do_load(4'hC, 4'd3);
        n_vec++; if (q1 !== 8'h93) begin n_err++; $display("FAIL clamp_C3 got %h exp 93", q1); end
        do_load(4'd2, 4'hB);
        n_vec++; if (q1 !== 8'h29) begin n_err++; $display("FAIL clamp_2B got %h exp 29", q1); end
        ld_tens = 4'd5; ld_ones = 4'd5; clr = 1; load = 1; en = 1;
        tick(); idle();
        n_vec++; if (q1 !== 8'h00 || q4 !== 8'h00) begin n_err++; $display("FAIL clr_over_load got %h/%h exp 00", q1, q4); end
    endtask

    task automatic test_en_gating();
        logic [5:0] en_seq;
        en_seq = 6'b111001; // applied LSB first: 1,0,0,1,1,1
        do_reset(); up = 1;
        for (int i = 0; i < 6; i++) begin
            en = en_seq[i];
            tick();
            n_vec++; if (q4 !== ((i == 5) ? 8'h01 : 8'h00) || d4_carry !== 1'b0) begin n_err++; $display("FAIL en_gate_i%0d got %h c=%b exp %h c=0", i, q4, d4_carry, (i == 5) ? 8'h01 : 8'h00); end
        end
        // Hold with en=0 on the per-cycle instance.
        do_load(4'd4, 4'd2); en = 0;
        tick(); tick(); tick();
        n_vec++; if (q1 !== 8'h42) begin n_err++; $display("FAIL en_hold got %h exp 42", q1); end
        idle();
    endtask

    task automatic test_direction_change();
        do_load(4'd5, 4'd0);
        en = 1; up = 1;
        tick();
        n_vec++; if (q1 !== 8'h51) begin n_err++; $display("FAIL dir_up got %h exp 51", q1); end
        up = 0;
        tick();
        n_vec++; if (q1 !== 8'h50) begin n_err++; $display("FAIL dir_down1 got %h exp 50", q1); end
        tick();
        n_vec++; if (q1 !== 8'h49) begin n_err++; $display("FAIL dir_down2 got %h exp 49", q1); end
        idle(); up = 1;
    endtask

    task automatic test_clr_prescaler();
        do_reset(); en = 1; up = 1;
        tick(); tick(); tick();
        en = 1; clr = 1;
        tick(); clr = 0;
        n_vec++; if (q4 !== 8'h00) begin n_err++; $display("FAIL clr_presc_q got %h exp 00", q4); end
        tick(); tick(); tick();
        n_vec++; if (q4 !== 8'h00) begin n_err++; $display("FAIL clr_presc_3 got %h exp 00", q4); end
        tick();
        n_vec++; if (q4 !== 8'h01) begin n_err++; $display("FAIL clr_presc_4 got %h exp 01", q4); end
        idle();
    endtask

    task automatic test_rst_priority();
        do_load(4'd9, 4'd9);
        rst = 1; load = 1; ld_tens = 4'd7; ld_ones = 4'd7; en = 1; up = 1;
        tick();
        rst = 0; load = 0;
        n_vec++; if (q1 !== 8'h00 || d1_carry !== 1'b0 || d1_borrow !== 1'b0) begin n_err++; $display("FAIL rst_prio got %h c=%b b=%b exp 00 c=0 b=0", q1, d1_carry, d1_borrow); end
        tick(); tick(); tick();
        n_vec++; if (q4 !== 8'h00) begin n_err++; $display("FAIL rst_resume_3 got %h exp 00", q4); end
        tick();
        n_vec++; if (q4 !== 8'h01) begin n_err++; $display("FAIL rst_resume_4 got %h exp 01", q4); end
        idle();
    endtask

    task automatic test_back_to_back();
        // Down across a tens boundary then back up, one step per cycle.
        do_load(4'd1, 4'd0);
        en = 1; up = 0;
        tick();
        n_vec++; if (q1 !== 8'h09) begin n_err++; $display("FAIL b2b_09 got %h exp 09", q1); end
        up = 1;
        tick();
        n_vec++; if (q1 !== 8'h10) begin n_err++; $display("FAIL b2b_10 got %h exp 10", q1); end
        idle();
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_clamp();
        test_en_gating();
        test_direction_change();
        test_clr_prescaler();
        test_rst_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
